// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
//   Shared widths, row count and FSM state type for the sequential 16x16
//   row multiplier (pp_row_sequencer) and its row adder.
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_W    = 16;  // operand width, fixed by the row adder
    localparam int PROD_W    = 32;  // full unsigned product width
    localparam int ROW_STEPS = 15;  // rows 1..15 retire after row 0 is loaded
    localparam int STEP_W    = 4;   // width of the row counter

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/adder_16bit.sv
// -----------------------------------------------------------------------------
// adder_16bit
//   One partial-product row adder. The running sum enters on in1 and is
//   shifted right one place internally, with the previous row's carry entering
//   at bit 15, so a chain of these (or one reused each clock) forms an
//   AND-array multiplier without external shift wiring.
//
//   Ports:
//     in1       in  16  running sum from the previous row (bit 0 is retired)
//     in2       in  16  this row's partial product
//     prev_cout in   1  carry out of the previous row, becomes bit 15
//     sum       out 16  row sum
//     cout      out  1  row carry out
//
//   {cout, sum} = {prev_cout, in1[15:1]} + in2
// -----------------------------------------------------------------------------
module adder_16bit (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        prev_cout,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] shifted;
    logic [16:0] total;

    // Dropping in1[0] here is what retires one product bit per row.
    assign shifted     = {prev_cout, in1} >> 1;
    assign total       = shifted + {1'b0, in2};
    assign {cout, sum} = total;

endmodule : adder_16bit

// File: rtl/pp_row_sequencer.sv
// -----------------------------------------------------------------------------
// pp_row_sequencer
//   Sequential 16x16 unsigned multiplier. Row 0 of the AND array is loaded on
//   acceptance; rows 1..15 are added one per clock through a single
//   adder_16bit, retiring one low product bit per row. The 32-bit product is
//   presented behind a valid/ready handshake.
//
//   Ports:
//     clk        in   1  clock, rising edge
//     rst_n      in   1  asynchronous active-low reset
//     in_valid   in   1  operands a/b valid
//     in_ready   out  1  block can accept operands (IDLE only)
//     a          in  16  multiplicand, unsigned
//     b          in  16  multiplier, unsigned
//     out_valid  out  1  product valid (DONE only)
//     out_ready  in   1  consumer accepts product
//     product    out 32  a*b, unsigned; holds last result while IDLE
//
//   Timing: accept at edge E0, rows retire at E1..E15, out_valid high after
//   E15. One result per 17 cycles at best.
// -----------------------------------------------------------------------------
module pp_row_sequencer
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MULT_W-1:0]   a,
    input  logic [MULT_W-1:0]   b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   product
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ROW_STEPS);

    mult_state_t          state_q, state_d;
    logic [MULT_W-1:0]    opa_q, opa_d;
    logic [MULT_W-1:0]    opb_q, opb_d;
    logic [MULT_W-1:0]    acc_q, acc_d;
    logic                 carry_q, carry_d;
    logic [MULT_W-2:0]    lo_q, lo_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [MULT_W-1:0]    pp_row;
    logic [MULT_W-1:0]    row_sum;
    logic                 row_cout;

    // Partial product for the current row.
    assign pp_row = opa_q & {MULT_W{opb_q[step_q]}};

    adder_16bit u_row_adder (
        .in1       (acc_q),
        .in2       (pp_row),
        .prev_cout (carry_q),
        .sum       (row_sum),
        .cout      (row_cout)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        lo_d    = lo_q;
        step_d  = step_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    opa_d   = a;
                    opb_d   = b;
                    acc_d   = a & {MULT_W{b[0]}};
                    carry_d = 1'b0;
                    step_d  = STEP_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // acc[0] is final once the row adder has shifted past it.
                lo_d[step_q - STEP_W'(1)] = acc_q[0];
                acc_d   = row_sum;
                carry_d = row_cout;
                step_d  = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            lo_q        <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            lo_q        <= lo_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    // Final carry is true bit 31: 0xFFFF*0xFFFF still fits in 32 bits.
    assign product   = {carry_q, acc_q, lo_q};

endmodule : pp_row_sequencer

// File: tb/tb_pp_row_sequencer.sv
module tb_pp_row_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int n_cmp = 0;
    int n_err = 0;

    pp_row_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, then count edges until out_valid rises.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Accept the product, confirm the block is back in IDLE the next cycle.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        chk({tag, "_ovalid_low"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_iready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic directed(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic [31:0] exp);
        int lat;
        out_ready = 1'b1;
        send(av, bv, lat);
        chk({tag, "_lat"}, 32'(lat), 32'd15);
        chk({tag, "_prod"}, product, exp);
        drain(tag);
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic [15:0] ra, rb;
        int          stall;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_product", product, 32'd0);
        #3 rst_n = 1'b1;
        tick();

        directed("t3x5", 16'd3, 16'd5, 32'h0000_000F);
        directed("tffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        directed("t8000", 16'h8000, 16'h8000, 32'h4000_0000);
        directed("tzero_a", 16'h0000, 16'h1234, 32'h0000_0000);
        directed("tzero_b", 16'h1234, 16'h0000, 32'h0000_0000);

        // Stall in DONE for 10 cycles while wiggling the inputs.
        out_ready = 1'b0;
        send(16'h1234, 16'h5678, lat);
        chk("stall_lat", 32'(lat), 32'd15);
        chk("stall_prod", product, 32'h0626_0060);
        held = product;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 16'hA5A5 ^ 16'(i);
            b        = 16'h5A5A + 16'(i);
            tick();
            chk("stall_ovalid", {31'd0, out_valid}, 32'd1);
            chk("stall_iready", {31'd0, in_ready}, 32'd0);
            chk("stall_hold", product, held);
        end
        in_valid = 1'b0;
        drain("stall");
        chk("stall_idle_hold", product, 32'h0626_0060);
        directed("post_stall", 16'h00FF, 16'h00FF, 32'h0000_FE01);

        // Reset at step 7 of an in-flight multiply.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'hABCD;
        b         = 16'h1357;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_iready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("arst_iready", {31'd0, in_ready}, 32'd1);
        chk("arst_product", product, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, in_ready}, 32'd1);
        directed("post_rst", 16'h00FF, 16'h0101, 32'h0000_FFFF);

        // Random pairs with random consumer stalls.
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k == 0) begin ra = 16'hFFFF; rb = 16'h0001; end
            stall     = $urandom_range(0, 3);
            out_ready = (stall == 0);
            send(ra, rb, lat);
            chk("rnd_lat", 32'(lat), 32'd15);
            chk("rnd_prod", product, 32'(ra) * 32'(rb));
            held = product;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("rnd_stall_hold", product, held);
            end
            out_ready = 1'b1;
            tick();
            chk("rnd_ovalid_low", {31'd0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_pp_row_sequencer
